muldiv_ctrl: RTL and testbench

Sequencing controller for the RV32M multiply/divide unit in the EX stage.
- Accepts one M-extension operation at a time from the issue logic over a valid/ready handshake.
- Multiply: registered 2-cycle path. Divide/remainder: iterative 32-step restoring divider.
- Returns the result over a valid/ready response channel; drives `busy` for pipeline stall logic; supports flush on branch mispredict or trap.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_ctrl_if.sv | 21 ++
 rtl/muldiv_ctrl_div_step.sv | 17 +
 rtl/muldiv_ctrl.sv | 121 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide controller.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response handshake bundle between issue logic and the muldiv controller.
interface muldiv_ctrl_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes; zero latency.
module div_step #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);
  logic [XLEN:0] sh_rem;
  logic [XLEN:0] trial;

  // Extra top bit keeps the shifted remainder exact; trial sign says "does not fit".
  assign sh_rem    = {rem, quot[XLEN-1]};
  assign trial     = sh_rem - {1'b0, divisor};
  assign rem_next  = trial[XLEN] ? sh_rem[XLEN-1:0] : trial[XLEN-1:0];
  assign quot_next = {quot[XLEN-2:0], ~trial[XLEN]};
endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: MUL result 2 cycles after accept, DIV XLEN+2, div special cases 1.
// One op in flight; result held in DONE until resp_ready; flush drops it.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_ctrl_if.slave bus,
  input  logic        flush,
  output logic        busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  op_e             op_q, req_op;
  logic [XLEN-1:0] a_q, b_q, rem_q, quot_q, res_q;
  logic [XLEN-1:0] step_rem, step_quot, mag_a, mag_b, special_res, div_res, mul_res;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [CW-1:0]   cnt_q;
  logic            q_neg_q, r_neg_q, fin_q;
  logic            accept, div_zero, div_ovf, special, neg_a, neg_b;

  assign req_op        = op_e'(bus.req_op);
  assign bus.req_ready = (state_q == ST_IDLE) & ~flush;
  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.resp_data = res_q;

  assign neg_a    = is_signed_a(req_op) & bus.req_rs1[XLEN-1];
  assign neg_b    = is_signed_b(req_op) & bus.req_rs2[XLEN-1];
  assign mag_a    = neg_a ? -bus.req_rs1 : bus.req_rs1;
  assign mag_b    = neg_b ? -bus.req_rs2 : bus.req_rs2;
  assign div_zero = (bus.req_rs2 == '0);
  assign div_ovf  = is_signed_a(req_op) & (bus.req_rs1 == MIN_NEG) & (bus.req_rs2 == '1);
  assign special  = is_div(req_op) & (div_zero | div_ovf);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = is_rem(req_op) ? bus.req_rs1 : '1;
    else
      special_res = is_rem(req_op) ? '0 : bus.req_rs1;
  end

  assign ext_a   = {{XLEN{is_signed_a(op_q) & a_q[XLEN-1]}}, a_q};
  assign ext_b   = {{XLEN{is_signed_b(op_q) & b_q[XLEN-1]}}, b_q};
  assign prod    = ext_a * ext_b;
  assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign div_res = is_rem(op_q) ? (r_neg_q ? -rem_q : rem_q)
                                : (q_neg_q ? -quot_q : quot_q);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quot     (quot_q),
    .divisor  (b_q),
    .rem_next (step_rem),
    .quot_next(step_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    busy           = (state_q != ST_IDLE);
    bus.resp_valid = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: if (accept) state_d = !is_div(req_op) ? ST_MUL : (special ? ST_DONE : ST_DIV);
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (fin_q) state_d = ST_DONE;
      ST_DONE: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Divide runs XLEN step cycles, then one extra DIV cycle applies the sign fix.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      fin_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= req_op;
      a_q     <= bus.req_rs1;
      b_q     <= is_div(req_op) ? mag_b : bus.req_rs2;
      quot_q  <= mag_a;
      rem_q   <= '0;
      cnt_q   <= CW'(XLEN - 1);
      fin_q   <= 1'b0;
      q_neg_q <= neg_a ^ neg_b;
      r_neg_q <= neg_a;
      if (special) res_q <= special_res;
    end else if (!flush) begin
      if (state_q == ST_MUL) begin
        res_q <= mul_res;
      end else if (state_q == ST_DIV) begin
        if (fin_q) begin
          res_q <= div_res;
        end else begin
          rem_q  <= step_rem;
          quot_q <= step_quot;
          if (cnt_q == '0) fin_q <= 1'b1;
          else             cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed scoreboard bench for muldiv_ctrl: driver queues expected results, monitor checks them.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  muldiv_ctrl_if #(.XLEN(32)) bus();

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .flush(flush),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples away from the edge and retires one expectation per handshake.
  initial begin : monitor
    bit          seen;
    int          first;
    logic [31:0] held;
    exp_t        e;
    seen = 0; first = 0; held = '0;
    forever begin
      @(negedge clk); #2;
      if (rst || !bus.resp_valid) begin
        seen = 0;
      end else begin
        if (!seen) begin
          seen = 1; first = cyc; held = bus.resp_data;
        end else begin
          chk("resp_stable", bus.resp_data, held);
        end
        if (bus.resp_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got 0x%08h expected no response (cycle %0d)", bus.resp_data, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", bus.resp_data, e.data);
            if (e.lat >= 0) chk("resp_latency", 32'(first - e.acc), 32'(e.lat));
          end
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input int lat, input bit push, output int acc);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    #1;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    acc = cyc;
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout: req_ready stayed 0 expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back('{data: exp_data, lat: lat, acc: acc});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d expected idle", busy, exp_q.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish expected completion");
    $fatal(1, "watchdog expired");
  end

  // op, rs1, rs2, expected, latency, special-case flag
  logic [2:0]  v_op  [12] = '{3'b011, 3'b001, 3'b010, 3'b000, 3'b100, 3'b110,
                              3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110};
  logic [31:0] v_a   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] v_b   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd6,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] v_exp [12] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h0000002A,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                              32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
  int          v_lat [12] = '{2, 2, 2, 2, 34, 34, 34, 34, 1, 1, 1, 1};

  initial begin : stim
    int acc;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      issue(v_op[i], v_a[i], v_b[i], v_exp[i], v_lat[i], 1'b1, acc);
      if (v_lat[i] == 1) begin
        #1;
        chk("special_busy_on", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("special_busy_off", 32'(busy), 32'd0);
      end
      wait_idle();
    end

    // Flush a divide mid-flight: no response, controller free the next cycle.
    issue(3'b101, 32'd1000, 32'd3, 32'd0, -1, 1'b0, acc);
    while (cyc < acc + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    issue(3'b000, 32'd3, 32'd3, 32'd9, 2, 1'b1, acc);
    wait_idle();

    // Response backpressure for three cycles with a competing request held up.
    bus.resp_ready = 1'b0;
    issue(3'b000, 32'd5, 32'd5, 32'd25, 2, 1'b1, acc);
    while (cyc < acc + 2) @(negedge clk);
    repeat (3) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b000;
      bus.req_rs1   = 32'd1;
      bus.req_rs2   = 32'd1;
      #1;
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    chk("stall_release_busy", 32'(busy), 32'd0);
    chk("stall_release_ready", 32'(bus.req_ready), 32'd1);
    wait_idle();

    // Synchronous reset in the middle of a divide.
    issue(3'b100, 32'd77, 32'd5, 32'd0, -1, 1'b0, acc);
    while (cyc < acc + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_resp_data", bus.resp_data, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'b011, 32'h00010000, 32'h00010000, 32'd1, 2, 1'b1, acc);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
